// File: rtl/sobol_pkg.sv
// Shared Sobol constants: direction-number tables and the direction-vector helper.
package sobol_pkg;

    localparam int unsigned MAX_W = 10;
    localparam logic [MAX_W-1:0] ALL_ONES = '1;

    typedef enum int unsigned {
        DIM_VDC   = 0,
        DIM_POLY1 = 1
    } dim_e;

    localparam int unsigned M_VDC   [MAX_W] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    localparam int unsigned M_POLY1 [MAX_W] = '{1, 3, 5, 15, 17, 51, 85, 255, 257, 771};

    // v[i] = m_{i+1} << (W-1-i), truncated to W bits
    function automatic logic [MAX_W-1:0] dir_vec(input int unsigned dim,
                                                 input int unsigned i,
                                                 input int unsigned w);
        int unsigned m;
        int unsigned val;
        m   = (dim == DIM_POLY1) ? M_POLY1[i] : M_VDC[i];
        val = (m << (w - 1 - i)) & ((32'd1 << w) - 1);
        return val[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/sobol_rng_dim_lsz.sv
// Least-significant-zero search; returns 0 when the input has no zero bit.
module LSZ #(
    parameter int unsigned INWD    = 8,
    parameter int unsigned LOGINWD = 3
) (
    input  logic [INWD-1:0]    in,
    output logic [LOGINWD-1:0] lszIdx
);

    logic found;

    always_comb begin
        lszIdx = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < INWD; i++) begin
            if (!found && !in[i]) begin
                lszIdx = LOGINWD'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sobol_rng_dim.sv
// One Sobol dimension: index counter, LSZ search and Gray-code XOR recurrence.
module sobol_rng_dim
    import sobol_pkg::*;
#(
    parameter int unsigned INWD    = 8,
    parameter int unsigned LOGINWD = 3,
    parameter int unsigned DIM     = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clr,
    output logic [INWD-1:0] out,
    output logic [INWD-1:0] cnt,
    output logic            wrap
);

    if (!(INWD == 6 || INWD == 8 || INWD == 10)) begin : g_bad_width
        $error("sobol_rng_dim: unsupported INWD %0d", INWD);
    end
    if (LOGINWD != $clog2(INWD)) begin : g_bad_logwidth
        $error("sobol_rng_dim: LOGINWD %0d does not match INWD %0d", LOGINWD, INWD);
    end
    if (DIM > 1) begin : g_bad_dim
        $error("sobol_rng_dim: unsupported DIM %0d", DIM);
    end

    logic [INWD-1:0]    dir_tab [INWD];
    logic [LOGINWD-1:0] lsz_idx;
    logic [LOGINWD-1:0] idx;
    logic [INWD-1:0]    dir;
    logic               at_top;

    for (genvar g = 0; g < INWD; g++) begin : g_dir
        assign dir_tab[g] = INWD'(dir_vec(DIM, g, INWD));
    end

    LSZ #(
        .INWD    (INWD),
        .LOGINWD (LOGINWD)
    ) u_lsz (
        .in     (cnt),
        .lszIdx (lsz_idx)
    );

    // All-ones count has no zero; stepping v[W-1] closes the period at out == 0
    always_comb begin
        at_top = (cnt == ALL_ONES[INWD-1:0]);
        idx    = at_top ? LOGINWD'(INWD - 1) : lsz_idx;
        dir    = dir_tab[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out  <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (clr) begin
            out  <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (en) begin
            out  <= out ^ dir;
            cnt  <= cnt + INWD'(1);
            wrap <= at_top;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobol_rng_dim.sv
// Bench for sobol_rng_dim (W=8, both dimensions) against a Gray-code Sobol model.
module tb_sobol_rng_dim;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [7:0] out0, cnt0, out1, cnt1;
    logic       wrap0, wrap1;

    int n_cmp;
    int n_err;
    int n_model;
    int wrap_exp;
    bit seen0 [256];
    bit seen1 [256];

    int m_tab [2][8] = '{'{1, 1, 1, 1, 1, 1, 1, 1},
                         '{1, 3, 5, 15, 17, 51, 85, 255}};

    sobol_rng_dim #(.INWD(8), .LOGINWD(3), .DIM(0)) u_dim0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .out(out0), .cnt(cnt0), .wrap(wrap0)
    );

    sobol_rng_dim #(.INWD(8), .LOGINWD(3), .DIM(1)) u_dim1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .out(out1), .cnt(cnt1), .wrap(wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sample n is the XOR of direction vectors selected by the set bits of gray(n)
    function automatic int sobol(input int dim, input int n);
        int g, x;
        g = n ^ (n >> 1);
        x = 0;
        for (int i = 0; i < 8; i++)
            if ((g >> i) & 1) x ^= (m_tab[dim][i] << (7 - i)) & 255;
        return x;
    endfunction

    task automatic step(input bit e, input bit c, input bit r);
        rst_n = r;
        en    = e;
        clr   = c;
        @(posedge clk);
        #1;
        if (!r || c) begin
            n_model  = 0;
            wrap_exp = 0;
        end else if (e) begin
            wrap_exp = (n_model == 255) ? 1 : 0;
            n_model  = (n_model + 1) % 256;
        end else begin
            wrap_exp = 0;
        end
        check("cnt0", cnt0, n_model);
        check("cnt1", cnt1, n_model);
        check("out0", out0, sobol(0, n_model));
        check("out1", out1, sobol(1, n_model));
        check("wrap0", wrap0, wrap_exp);
        check("wrap1", wrap1, wrap_exp);
    endtask

    initial begin
        int exp0 [7] = '{128, 192, 64, 96, 224, 160, 32};
        int exp1 [7] = '{128, 64, 192, 96, 224, 32, 160};
        int tog_en [5] = '{1, 0, 0, 1, 1};
        int tog_out [5] = '{128, 128, 128, 192, 64};
        int wraps;

        n_cmp = 0; n_err = 0; n_model = 0; wrap_exp = 0;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0;

        step(1, 1, 0);
        step(0, 0, 0);
        check("rst_out0", out0, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_wrap0", wrap0, 0);

        for (int k = 0; k < 7; k++) begin
            step(1, 0, 1);
            check("seq_dim0", out0, exp0[k]);
            check("seq_dim1", out1, exp1[k]);
            check("seq_cnt", cnt0, k + 1);
        end

        // full period from reset
        step(0, 0, 0);
        seen0[0] = 1'b1;
        seen1[0] = 1'b1;
        for (int k = 1; k < 256; k++) begin
            step(1, 0, 1);
            check("uniq0", seen0[out0], 0);
            check("uniq1", seen1[out1], 0);
            seen0[out0] = 1'b1;
            seen1[out1] = 1'b1;
        end
        check("top_cnt", cnt0, 255);
        check("top_out0", out0, 1);
        check("top_out1", out1, 255);
        step(1, 0, 1);
        check("wrap_out0", out0, 0);
        check("wrap_cnt0", cnt0, 0);
        check("wrap_pulse", wrap0, 1);
        step(0, 0, 1);
        check("wrap_clear", wrap0, 0);

        // gaps in en
        step(0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(tog_en[k][0], 0, 1);
            check("gap_out0", out0, tog_out[k]);
            check("gap_wrap", wrap0, 0);
        end

        // clr wins over en
        step(0, 0, 0);
        for (int k = 0; k < 5; k++) step(1, 0, 1);
        check("pre_clr_cnt", cnt0, 5);
        step(1, 1, 1);
        check("clr_out0", out0, 0);
        check("clr_cnt0", cnt0, 0);
        step(1, 0, 1);
        check("post_clr_out0", out0, 128);

        // mid-sequence reset with en high
        for (int k = 0; k < 9; k++) step(1, 0, 1);
        step(1, 0, 0);
        check("mid_rst_out0", out0, 0);
        check("mid_rst_cnt0", cnt0, 0);
        check("mid_rst_wrap", wrap0, 0);
        step(1, 0, 1);
        check("post_rst_out0", out0, 128);

        // random en / rare clr, long enough to cross several wraps
        wraps = 0;
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, 1);
            if (wrap_exp != 0) wraps++;
        end
        check("rand_wraps_seen", (wraps > 0) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
